// File: rtl/l2_port_arbiter.sv
// rtl/l2_port_arbiter.sv - two-to-one Wishbone line-port arbiter (ifetch/data -> L2)
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   if_cyc/if_stb/if_adr        ifetch master request (read-only); if_ack completion
//   dm_cyc/dm_stb/dm_we/dm_adr  data master request; dm_sel byte enables,
//   dm_sel/dm_dat_m             dm_dat_m write line; dm_ack completion
//   up_dat_s                    read line broadcast to both masters
//   pm_*                        shared downstream line port
//   grant_cnt_if/grant_cnt_dm   saturating grants issued per port
//   wait_cnt                    saturating cycles with an ungranted request

module l2_port_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_cyc,
    input  logic             if_stb,
    input  logic [11:0]      if_adr,
    output logic             if_ack,
    input  logic             dm_cyc,
    input  logic             dm_stb,
    input  logic             dm_we,
    input  logic [11:0]      dm_adr,
    input  logic [15:0]      dm_sel,
    input  logic [127:0]     dm_dat_m,
    output logic             dm_ack,
    output logic [127:0]     up_dat_s,
    output logic             pm_cyc,
    output logic             pm_stb,
    output logic             pm_we,
    output logic [11:0]      pm_adr,
    output logic [15:0]      pm_sel,
    output logic [127:0]     pm_dat_m,
    input  logic [127:0]     pm_dat_s,
    input  logic             pm_ack,
    output logic [CNT_W-1:0] grant_cnt_if,
    output logic [CNT_W-1:0] grant_cnt_dm,
    output logic [CNT_W-1:0] wait_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_DM = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   last_dm;            // 1 = data port was granted most recently
    logic   grant_if, grant_dm; // one-cycle pulses on the IDLE->GNT edge
    logic   if_req, dm_req;
    logic   waiting;

    assign if_req   = if_cyc & if_stb;
    assign dm_req   = dm_cyc & dm_stb;
    assign up_dat_s = pm_dat_s;

    // A requester waits in any cycle it asks but does not own the port,
    // including the arbitration cycle spent in IDLE.
    assign waiting = (if_req && state != GNT_IF) || (dm_req && state != GNT_DM);

    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_dm  = 1'b0;
        pm_cyc    = 1'b0;
        pm_stb    = 1'b0;
        pm_we     = 1'b0;
        pm_adr    = '0;
        pm_sel    = '0;
        pm_dat_m  = '0;
        if_ack    = 1'b0;
        dm_ack    = 1'b0;
        // Output drive is gated on rst_n directly so the port goes quiet in
        // the very cycle reset is asserted, not one edge later.
        if (rst_n) begin
            case (state)
                IDLE: begin
                    if (if_req && dm_req) begin
                        // Tie: favour the port that did not go last.
                        if (last_dm) begin
                            grant_if  = 1'b1;
                            state_nxt = GNT_IF;
                        end else begin
                            grant_dm  = 1'b1;
                            state_nxt = GNT_DM;
                        end
                    end else if (if_req) begin
                        grant_if  = 1'b1;
                        state_nxt = GNT_IF;
                    end else if (dm_req) begin
                        grant_dm  = 1'b1;
                        state_nxt = GNT_DM;
                    end
                end
                GNT_IF: begin
                    pm_cyc = if_req;
                    pm_stb = if_req;
                    pm_adr = if_adr;
                    pm_sel = 16'hFFFF;   // ifetch always reads a full line
                    if (pm_ack) begin
                        if_ack    = 1'b1;
                        state_nxt = IDLE;
                    end else if (!if_cyc) begin
                        state_nxt = IDLE;  // abort: any later ack lands in IDLE and is dropped
                    end
                end
                GNT_DM: begin
                    pm_cyc   = dm_req;
                    pm_stb   = dm_req;
                    pm_we    = dm_we;
                    pm_adr   = dm_adr;
                    pm_sel   = dm_sel;
                    pm_dat_m = dm_dat_m;
                    if (pm_ack) begin
                        dm_ack    = 1'b1;
                        state_nxt = IDLE;
                    end else if (!dm_cyc) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_dm      <= 1'b0;
            grant_cnt_if <= '0;
            grant_cnt_dm <= '0;
            wait_cnt     <= '0;
        end else begin
            state <= state_nxt;
            if (grant_if) begin
                last_dm <= 1'b0;
                if (grant_cnt_if != '1)
                    grant_cnt_if <= grant_cnt_if + 1'b1;
            end
            if (grant_dm) begin
                last_dm <= 1'b1;
                if (grant_cnt_dm != '1)
                    grant_cnt_dm <= grant_cnt_dm + 1'b1;
            end
            if (waiting && wait_cnt != '1)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb/tb_l2_port_arbiter.sv - directed self-checking bench for l2_port_arbiter

module tb_l2_port_arbiter;

    localparam logic [127:0] DAT  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] WDAT = {16{8'hA5}};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         if_cyc, if_stb, dm_cyc, dm_stb, dm_we, pm_ack;
    logic [11:0]  if_adr, dm_adr;
    logic [15:0]  dm_sel;
    logic [127:0] dm_dat_m, pm_dat_s;

    logic         if_ack, dm_ack, pm_cyc, pm_stb, pm_we;
    logic [11:0]  pm_adr;
    logic [15:0]  pm_sel;
    logic [127:0] up_dat_s, pm_dat_m;
    logic [15:0]  grant_cnt_if, grant_cnt_dm, wait_cnt;

    logic         s_if_ack, s_dm_ack, s_pm_cyc, s_pm_stb, s_pm_we;
    logic [11:0]  s_pm_adr;
    logic [15:0]  s_pm_sel;
    logic [127:0] s_up_dat_s, s_pm_dat_m;
    logic [1:0]   s_grant_cnt_if, s_grant_cnt_dm, s_wait_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    l2_port_arbiter #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_cyc(if_cyc), .if_stb(if_stb), .if_adr(if_adr), .if_ack(if_ack),
        .dm_cyc(dm_cyc), .dm_stb(dm_stb), .dm_we(dm_we), .dm_adr(dm_adr),
        .dm_sel(dm_sel), .dm_dat_m(dm_dat_m), .dm_ack(dm_ack),
        .up_dat_s(up_dat_s),
        .pm_cyc(pm_cyc), .pm_stb(pm_stb), .pm_we(pm_we), .pm_adr(pm_adr),
        .pm_sel(pm_sel), .pm_dat_m(pm_dat_m), .pm_dat_s(pm_dat_s), .pm_ack(pm_ack),
        .grant_cnt_if(grant_cnt_if), .grant_cnt_dm(grant_cnt_dm), .wait_cnt(wait_cnt)
    );

    // Narrow-counter copy on the same stimulus, used to reach saturation quickly.
    l2_port_arbiter #(.CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .if_cyc(if_cyc), .if_stb(if_stb), .if_adr(if_adr), .if_ack(s_if_ack),
        .dm_cyc(dm_cyc), .dm_stb(dm_stb), .dm_we(dm_we), .dm_adr(dm_adr),
        .dm_sel(dm_sel), .dm_dat_m(dm_dat_m), .dm_ack(s_dm_ack),
        .up_dat_s(s_up_dat_s),
        .pm_cyc(s_pm_cyc), .pm_stb(s_pm_stb), .pm_we(s_pm_we), .pm_adr(s_pm_adr),
        .pm_sel(s_pm_sel), .pm_dat_m(s_pm_dat_m), .pm_dat_s(pm_dat_s), .pm_ack(pm_ack),
        .grant_cnt_if(s_grant_cnt_if), .grant_cnt_dm(s_grant_cnt_dm), .wait_cnt(s_wait_cnt)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #4;
    endtask

    initial begin
        rst_n = 1'b0;
        if_cyc = 1'b1; if_stb = 1'b1; if_adr = 12'h000;
        dm_cyc = 1'b0; dm_stb = 1'b0; dm_we = 1'b0; dm_adr = 12'h000;
        dm_sel = 16'h0000; dm_dat_m = '0; pm_dat_s = DAT; pm_ack = 1'b1;

        // Reset with a live request and ack: everything must stay quiet.
        step; step; settle;
        chk("rst_pm_cyc", pm_cyc, 0);
        chk("rst_if_ack", if_ack, 0);
        chk("rst_pm_sel", pm_sel, 0);
        step; if_cyc = 0; if_stb = 0; pm_ack = 0; rst_n = 1; settle;
        chk("rst_gnt_if", grant_cnt_if, 0);
        chk("rst_gnt_dm", grant_cnt_dm, 0);
        chk("rst_wait", wait_cnt, 0);

        // Single IF read, ack 3 cycles after pm_cyc rises.
        step; if_cyc = 1; if_stb = 1; if_adr = 12'h040; settle;
        chk("t1_latency", pm_cyc, 0);
        step; settle;
        chk("t1_pm_cyc", pm_cyc, 1);
        chk("t1_pm_stb", pm_stb, 1);
        chk("t1_pm_adr", pm_adr, 12'h040);
        chk("t1_pm_we", pm_we, 0);
        chk("t1_pm_sel", pm_sel, 16'hFFFF);
        chk("t1_pm_dat_m", pm_dat_m, 0);
        chk("t1_gnt_if", grant_cnt_if, 1);
        chk("t1_wait", wait_cnt, 1);
        step; settle;
        chk("t1_no_ack_a", if_ack, 0);
        step; settle;
        chk("t1_no_ack_b", if_ack, 0);
        step; pm_ack = 1; settle;
        chk("t1_if_ack", if_ack, 1);
        chk("t1_dm_ack", dm_ack, 0);
        chk("t1_up_dat", up_dat_s, DAT);
        step; pm_ack = 0; if_cyc = 0; if_stb = 0; settle;
        chk("t1_idle_cyc", pm_cyc, 0);
        chk("t1_idle_ack", if_ack, 0);
        chk("t1_wait_end", wait_cnt, 1);

        // Tie right after reset: DM first, IF after DM ack + 1 idle cycle.
        step; rst_n = 0; settle;
        step; rst_n = 1;
        if_cyc = 1; if_stb = 1; if_adr = 12'h0C0;
        dm_cyc = 1; dm_stb = 1; dm_adr = 12'h100; dm_we = 0; dm_sel = 16'hFFFF;
        settle;
        chk("t2_arb_cyc", pm_cyc, 0);
        step; settle;
        chk("t2_dm_adr", pm_adr, 12'h100);
        chk("t2_gnt_dm", grant_cnt_dm, 1);
        chk("t2_gnt_if", grant_cnt_if, 0);
        chk("t2_wait_a", wait_cnt, 1);
        step; pm_ack = 1; settle;
        chk("t2_dm_ack", dm_ack, 1);
        chk("t2_if_ack0", if_ack, 0);
        chk("t2_wait_b", wait_cnt, 2);
        step; pm_ack = 0; dm_cyc = 0; dm_stb = 0; settle;
        chk("t2_idle_cyc", pm_cyc, 0);
        chk("t2_wait_c", wait_cnt, 3);
        step; pm_ack = 1; settle;
        chk("t2_if_adr", pm_adr, 12'h0C0);
        chk("t2_if_ack", if_ack, 1);
        chk("t2_gnt_if1", grant_cnt_if, 1);
        chk("t2_wait_d", wait_cnt, 4);
        step; pm_ack = 0; if_cyc = 0; if_stb = 0; settle;
        chk("t2_wait_end", wait_cnt, 4);

        // Both held for 6 transactions: strict alternation starting with DM.
        step; rst_n = 0; settle;
        step; rst_n = 1; if_cyc = 1; if_stb = 1; dm_cyc = 1; dm_stb = 1; settle;
        for (int i = 0; i < 6; i++) begin
            step; pm_ack = 1; settle;
            chk($sformatf("t3_adr_%0d", i), pm_adr, (i % 2 == 0) ? 12'h100 : 12'h0C0);
            chk($sformatf("t3_dm_ack_%0d", i), dm_ack, (i % 2 == 0) ? 1'b1 : 1'b0);
            chk($sformatf("t3_if_ack_%0d", i), if_ack, (i % 2 == 0) ? 1'b0 : 1'b1);
            step; pm_ack = 0;
            if (i == 5) begin
                if_cyc = 0; if_stb = 0; dm_cyc = 0; dm_stb = 0;
            end
            settle;
        end
        chk("t3_gnt_if", grant_cnt_if, 3);
        chk("t3_gnt_dm", grant_cnt_dm, 3);
        chk("t3_wait", wait_cnt, 12);
        chk("t3_sat_gnt_if", s_grant_cnt_if, 3);
        chk("t3_sat_gnt_dm", s_grant_cnt_dm, 3);
        chk("t3_sat_wait", s_wait_cnt, 3);

        // DM write passthrough; IF arriving mid-transaction must not disturb pm_*.
        step; dm_cyc = 1; dm_stb = 1; dm_we = 1; dm_sel = 16'h000F;
        dm_dat_m = WDAT; dm_adr = 12'h2AB; settle;
        step; settle;
        chk("t4_pm_we", pm_we, 1);
        chk("t4_pm_sel", pm_sel, 16'h000F);
        chk("t4_pm_dat_m", pm_dat_m, WDAT);
        chk("t4_pm_adr", pm_adr, 12'h2AB);
        chk("t4_gnt_dm", grant_cnt_dm, 4);
        if_cyc = 1; if_stb = 1; if_adr = 12'h055; #1;
        chk("t4_mid_adr", pm_adr, 12'h2AB);
        chk("t4_mid_we", pm_we, 1);
        step; pm_ack = 1; settle;
        chk("t4_dm_ack", dm_ack, 1);
        chk("t4_if_ack0", if_ack, 0);
        chk("t4_ack_dat", pm_dat_m, WDAT);
        step; pm_ack = 0; dm_cyc = 0; dm_stb = 0; dm_we = 0; settle;
        chk("t4_idle_cyc", pm_cyc, 0);
        step; settle;
        chk("t4_if_adr", pm_adr, 12'h055);
        chk("t4_if_we", pm_we, 0);
        chk("t4_if_dat", pm_dat_m, 0);
        chk("t4_if_sel", pm_sel, 16'hFFFF);
        chk("t4_wait", wait_cnt, 16);
        chk("t4_sat_gnt_dm", s_grant_cnt_dm, 3);
        step; pm_ack = 1; settle;
        chk("t4_if_ack", if_ack, 1);
        step; pm_ack = 0; if_cyc = 0; if_stb = 0; settle;

        // Abort: DM drops cyc, late ack ignored, pending IF served next.
        step; dm_cyc = 1; dm_stb = 1; dm_adr = 12'h3C0; settle;
        step; if_cyc = 1; if_stb = 1; if_adr = 12'h0AA; settle;
        chk("t5_dm_adr", pm_adr, 12'h3C0);
        chk("t5_gnt_dm", grant_cnt_dm, 5);
        step; dm_cyc = 0; settle;
        chk("t5_abort_cyc", pm_cyc, 0);
        chk("t5_abort_ack", dm_ack, 0);
        step; pm_ack = 1; settle;
        chk("t5_late_dm_ack", dm_ack, 0);
        chk("t5_late_if_ack", if_ack, 0);
        chk("t5_idle_cyc", pm_cyc, 0);
        step; pm_ack = 0; dm_stb = 0; settle;
        chk("t5_if_cyc", pm_cyc, 1);
        chk("t5_if_adr", pm_adr, 12'h0AA);
        chk("t5_gnt_if", grant_cnt_if, 5);

        // Reset pulsed during GNT_IF.
        step; rst_n = 0; pm_ack = 1; settle;
        chk("t6_rst_cyc", pm_cyc, 0);
        chk("t6_rst_ack", if_ack, 0);
        chk("t6_rst_adr", pm_adr, 0);
        step; rst_n = 1; pm_ack = 0; settle;
        chk("t6_gnt_if", grant_cnt_if, 0);
        chk("t6_gnt_dm", grant_cnt_dm, 0);
        chk("t6_wait", wait_cnt, 0);
        chk("t6_sat_gnt_dm", s_grant_cnt_dm, 0);
        chk("t6_idle_cyc", pm_cyc, 0);
        step; settle;
        chk("t6_regrant_cyc", pm_cyc, 1);
        chk("t6_regrant_cnt", grant_cnt_if, 1);
        chk("t6_regrant_wait", wait_cnt, 1);
        step; if_cyc = 0; if_stb = 0; settle;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/l2_port_arbiter.md
# l2_port_arbiter

Two-to-one Wishbone arbiter between the CPU's instruction-fetch master and data-memory master and a single shared downstream line port (L2 or physical memory). Serves one 128-bit line transaction at a time. Alternates priority on contention, holds a grant until the downstream ACK or a requester abort, and keeps saturating grant and wait counters for performance debug. Sits between the pipeline's `ifetch`/`memory` bus masters and the next memory level.

## Interface
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous reset, active low.
- `if_cyc`, `if_stb`  in  1 each  ifetch request; read-only master.
- `if_adr`  in  12  ifetch line address.
- `if_ack`  out  1  ifetch completion.
- `dm_cyc`, `dm_stb`, `dm_we`  in  1 each  data request and direction.
- `dm_adr`  in  12  data line address.
- `dm_sel`  in  16  data byte enables.
- `dm_dat_m`  in  128  data write line.
- `dm_ack`  out  1  data completion.
- `up_dat_s`  out  128  read line, broadcast to both masters (= `pm_dat_s`).
- `pm_cyc`, `pm_stb`, `pm_we`  out  1 each  downstream request.
- `pm_adr`  out  12  downstream address.
- `pm_sel`  out  16  downstream byte enables.
- `pm_dat_m`  out  128  downstream write data.
- `pm_dat_s`  in  128  downstream read data.
- `pm_ack`  in  1  downstream completion.
- `grant_cnt_if`, `grant_cnt_dm`  out  CNT_W  grants issued per port, saturating.
- `wait_cnt`  out  CNT_W  cycles in which some requester had `cyc&stb` high but no grant, saturating.

## Operation
- A request is `x_cyc & x_stb`.
- States: IDLE, GNT_IF, GNT_DM. Register `last` records the most recently granted port. Reset value of `last` = IF.
- IDLE:
  - Only IF requests: go to GNT_IF.
  - Only DM requests: go to GNT_DM.
  - Both request: grant the port that is not `last`. After reset, DM wins the first tie.
  - Neither requests: stay in IDLE.
  - On every grant: update `last` and increment that port's grant counter.
- GNT_x, downstream drive (combinational from state):
  - `pm_cyc`/`pm_stb` = requester's `cyc&stb`.
  - GNT_DM: `pm_adr`, `pm_we`, `pm_sel`, `pm_dat_m` pass through from the `dm_` inputs.
  - GNT_IF: `pm_adr` = `if_adr`, `pm_we` = 0, `pm_sel` = 16'hFFFF, `pm_dat_m` = 0.
- GNT_x, exit:
  - `pm_ack` high: route it combinationally to `x_ack` in the same cycle; next state IDLE.
  - Requester drops `cyc` before the ACK (abort): next state IDLE. A late `pm_ack` is discarded.
- Ungranted port's ack is always 0. `up_dat_s` = `pm_dat_s` at all times.
- In IDLE, and whenever `rst_n` = 0: all `pm_*` outputs and both acks are 0. This gating is combinational on `rst_n`.
- Counters saturate at all-ones. `wait_cnt` counts any cycle, IDLE included, in which a requester is asserted and not currently granted.

## Timing
- Reset: state IDLE, `last` = IF, all counters 0, all outputs 0 during and after reset until the first grant.
- Grant latency: request sampled in IDLE at edge k; `pm_cyc` rises in the cycle after edge k, so minimum 1 cycle of arbitration.
- Completion: `x_ack` is coincident with `pm_ack`.
- Turnaround: there is always exactly one IDLE cycle after each ACK or abort. The finished master gets that cycle to drop `cyc`. Back-to-back requests cost at least 1 extra cycle each.
- Two ports continuously requesting: grants strictly alternate IF/DM. No port waits more than one other transaction.
- `pm_ack` while IDLE: ignored, no ack forwarded.
- `rst_n` low mid-transaction: next state IDLE, outputs 0 immediately, counters cleared. The requester must reissue.

## Test plan
- Reset, then single IF read at `if_adr`=12'h040, with `pm_ack` 3 cycles after `pm_cyc` rises:
  - `pm_adr`=040, `pm_we`=0, `pm_sel`=FFFF.
  - `if_ack` is coincident with `pm_ack` and `up_dat_s`=`pm_dat_s`.
  - `dm_ack`=0 throughout; `grant_cnt_if`=1.
- IF and DM both request in the same cycle right after reset: DM granted first, IF granted after the DM ACK plus 1 IDLE cycle, `wait_cnt` increments every cycle IF waits.
- Both held requesting for 6 transactions: grant order DM, IF, DM, IF, DM, IF; `grant_cnt_if`=`grant_cnt_dm`=3.
- DM write (`dm_we`=1, `dm_sel`=000F, `dm_dat_m`=128'hA5…): exact passthrough on `pm_*`; IF requesting mid-transaction has no effect on `pm_*` until DM is ACKed.
- Abort: DM drops `cyc` before the ACK, `pm_ack` arrives 1 cycle later → `dm_ack` stays 0, state IDLE, the pending IF request is granted next.
- `rst_n` pulsed low during GNT_IF: `pm_cyc`=0 in the same cycle, counters 0, IDLE after release; force counter values near all-ones and confirm saturation.
